// File: rtl/brisc_pkg.sv
// Shared encodings for the brisc control path: opcodes, ALU selects, FSM states, op classes.
package brisc_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDI = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_CNT = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_INV = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SR  = 4'd9;
    localparam logic [3:0] OP_SL  = 4'd10;
    localparam logic [3:0] OP_IN  = 4'd11;
    localparam logic [3:0] OP_OUT = 4'd12;
    localparam logic [3:0] OP_JZ  = 4'd13;
    localparam logic [3:0] OP_JLT = 4'd14;
    localparam logic [3:0] OP_J   = 4'd15;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_CNT_INV = 3'b010;
    localparam logic [2:0] ALU_XOR_SL  = 3'b011;
    localparam logic [2:0] ALU_SR      = 3'b100;
    localparam logic [2:0] ALU_AND     = 3'b101;
    localparam logic [2:0] ALU_OR      = 3'b110;
    localparam logic [2:0] ALU_PASS    = 3'b111;
    // Idle value of alu_control whenever nothing executes.
    localparam logic [2:0] ALU_NOP     = ALU_SUB;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StWaitIo
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu,
        ClsIn,
        ClsOut,
        ClsJz,
        ClsJlt,
        ClsJmp
    } op_class_e;

endpackage

// File: rtl/brisc_decode.sv
// Combinational opcode decode: ALU select, immediate select, op class, flag update, illegal.
module brisc_decode
    import brisc_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    output logic [2:0]     o_alu_op,
    output logic           o_im_sel,
    output logic [2:0]     o_class,
    output logic           o_upd_flags,
    output logic           o_illegal
);

    logic      w_hi;
    op_class_e w_cls;

    if (OPW > 4) begin : g_wide
        assign w_hi = |i_opcode[OPW-1:4];
    end else begin : g_narrow
        assign w_hi = 1'b0;
    end

    always_comb begin
        o_alu_op    = ALU_NOP;
        o_im_sel    = 1'b0;
        w_cls       = ClsNop;
        o_upd_flags = 1'b0;
        o_illegal   = w_hi;
        // Anything beyond the 16 defined opcodes degrades to a NOP.
        if (!w_hi) begin
            unique case (i_opcode[3:0])
                OP_NOP: ;
                OP_ADD: begin o_alu_op = ALU_ADD;     w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_LDI: begin o_alu_op = ALU_PASS;    w_cls = ClsAlu; o_im_sel = 1'b1;    end
                OP_SUB: begin o_alu_op = ALU_SUB;     w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_CNT: begin o_alu_op = ALU_CNT_INV; w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_AND: begin o_alu_op = ALU_AND;     w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_OR:  begin o_alu_op = ALU_OR;      w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_INV: begin o_alu_op = ALU_CNT_INV; w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_XOR: begin o_alu_op = ALU_XOR_SL;  w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_SR:  begin o_alu_op = ALU_SR;      w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_SL:  begin o_alu_op = ALU_XOR_SL;  w_cls = ClsAlu; o_upd_flags = 1'b1; end
                OP_IN:  begin o_alu_op = ALU_PASS;    w_cls = ClsIn;  end
                OP_OUT: begin o_alu_op = ALU_PASS;    w_cls = ClsOut; end
                OP_JZ:  begin o_alu_op = ALU_PASS;    w_cls = ClsJz;  end
                OP_JLT: begin o_alu_op = ALU_PASS;    w_cls = ClsJlt; end
                OP_J:   begin o_alu_op = ALU_PASS;    w_cls = ClsJmp; end
            endcase
        end
    end

    assign o_class = w_cls;

endmodule

// File: rtl/brisc_ctrl_fsm.sv
// brisc control FSM: FETCH/EXEC/WAIT_IO sequencing, flag latches, sticky illegal flag.
module brisc_ctrl_fsm
    import brisc_pkg::*;
#(
    parameter int unsigned OPW      = 4,
    parameter int unsigned ALUW     = 3,
    parameter int unsigned FLAG_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            lt,
    input  logic            in_valid,
    input  logic            out_ready,
    output logic            instr_ready,
    output logic [ALUW-1:0] alu_control,
    output logic            im_sel,
    output logic            write_enable,
    output logic            out_write_en,
    output logic            in_mux_en,
    output logic            jump_en,
    output logic            pc_en,
    output logic            busy,
    output logic            illegal
);

    state_e         r_state;
    state_e         w_state_next;
    logic [OPW-1:0] r_opcode;
    logic           r_flag_z;
    logic           r_flag_lt;
    logic           r_illegal;

    logic [2:0]     w_dec_alu;
    logic           w_dec_im;
    logic [2:0]     w_dec_class;
    logic           w_dec_upd;
    logic           w_dec_illegal;
    op_class_e      w_cls;
    logic           w_z;
    logic           w_lt;
    logic           w_io_op;
    logic           w_io_done;
    logic [2:0]     w_alu;

    brisc_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_opcode    (r_opcode),
        .o_alu_op    (w_dec_alu),
        .o_im_sel    (w_dec_im),
        .o_class     (w_dec_class),
        .o_upd_flags (w_dec_upd),
        .o_illegal   (w_dec_illegal)
    );

    assign w_cls     = op_class_e'(w_dec_class);
    assign w_z       = (FLAG_REG != 0) ? r_flag_z : zero;
    assign w_lt      = (FLAG_REG != 0) ? r_flag_lt : lt;
    assign w_io_op   = (w_cls == ClsIn) || (w_cls == ClsOut);
    assign w_io_done = ((w_cls == ClsIn) && in_valid) || ((w_cls == ClsOut) && out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch:  if (instr_valid) w_state_next = StExec;
            StExec:   w_state_next = (w_io_op && !w_io_done) ? StWaitIo : StFetch;
            StWaitIo: if (w_io_done || !w_io_op) w_state_next = StFetch;
            default:  w_state_next = StFetch;
        endcase
    end

    // Branches never update flags, so capture and evaluation cannot collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opcode  <= '0;
            r_flag_z  <= 1'b0;
            r_flag_lt <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == StFetch && instr_valid) begin
                r_opcode <= opcode;
            end
            if (r_state == StExec && w_dec_upd && FLAG_REG != 0) begin
                r_flag_z  <= zero;
                r_flag_lt <= lt;
            end
            if (r_state == StExec && w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        instr_ready  = (r_state == StFetch);
        busy         = (r_state != StFetch);
        illegal      = r_illegal;
        w_alu        = ALU_NOP;
        im_sel       = 1'b0;
        write_enable = 1'b0;
        out_write_en = 1'b0;
        in_mux_en    = 1'b0;
        jump_en      = 1'b0;
        pc_en        = 1'b0;
        // Strobes are gated by reset so an abandoned I/O wait never commits.
        if (rst_n && r_state != StFetch) begin
            if (r_state == StExec) begin
                w_alu  = w_dec_alu;
                im_sel = w_dec_im;
            end
            unique case (w_cls)
                ClsNop: pc_en = 1'b1;
                ClsAlu: begin
                    write_enable = 1'b1;
                    pc_en        = 1'b1;
                end
                ClsIn: begin
                    in_mux_en = 1'b1;
                    if (in_valid) begin
                        write_enable = 1'b1;
                        pc_en        = 1'b1;
                    end
                end
                ClsOut: begin
                    if (out_ready) begin
                        out_write_en = 1'b1;
                        pc_en        = 1'b1;
                    end
                end
                ClsJz: begin
                    if (w_z) jump_en = 1'b1;
                    else     pc_en   = 1'b1;
                end
                ClsJlt: begin
                    if (w_lt) jump_en = 1'b1;
                    else      pc_en   = 1'b1;
                end
                ClsJmp:  jump_en = 1'b1;
                default: ;
            endcase
        end
        alu_control      = '0;
        alu_control[2:0] = w_alu;
    end

endmodule

// File: doc/brisc_ctrl_fsm.md
BRISC_CTRL_FSM -- requirements
Module: brisc_ctrl_fsm

Interface
REQ-001 SHALL have parameter OPW, default 4: opcode width, minimum 4.
REQ-002 SHALL have parameter ALUW, default 3: alu_control width, minimum 3.
REQ-003 SHALL have parameter FLAG_REG, default 1: 1 = branches use latched flags, 0 = branches use live zero/lt.
REQ-004 SHALL have port clk, input, 1: the only clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port instr_valid, input, 1: opcode is valid.
REQ-007 SHALL have port opcode, input, OPW: instruction operation field.
REQ-008 SHALL have ports zero and lt, input, 1 each: ALU result flags, valid during EXEC.
REQ-009 SHALL have port in_valid, input, 1: external input data available.
REQ-010 SHALL have port out_ready, input, 1: external output sink can accept.
REQ-011 SHALL have port instr_ready, output, 1: high only in FETCH.
REQ-012 SHALL have port alu_control, output, ALUW: ALU op select, upper bits beyond 3 zero.
REQ-013 SHALL have ports im_sel, write_enable, out_write_en, in_mux_en and jump_en, output, 1 each: datapath strobes.
REQ-014 SHALL have port pc_en, output, 1: sequential PC advance pulse.
REQ-015 SHALL have ports busy, output, 1 (state != FETCH), and illegal, output, 1 (sticky).

Function
REQ-016 SHALL implement FSM states FETCH, EXEC and WAIT_IO.
REQ-017 SHALL, in FETCH, latch opcode when instr_valid and instr_ready are both high, then go to EXEC.
REQ-018 SHALL decode the latched opcode in EXEC as: 0 NOP/001, 1 ADD/000, 2 LDI/111 with im_sel, 3 SUB/001, 4 CNT/010, 5 AND/101, 6 OR/110, 7 INV/010, 8 XOR/011, 9 SR/100, 10 SL/011, 11 IN/111, 12 OUT/111, 13 JZ, 14 JLT, 15 J (13-15 drive 111).
REQ-019 SHALL, for ALU/LDI ops (1-10), assert write_enable and pc_en for exactly the one EXEC cycle, then return to FETCH.
REQ-020 SHALL, when FLAG_REG=1, capture zero/lt into flag_z/flag_lt in the EXEC cycle of opcodes 1, 3-10 only.
REQ-021 SHALL, for JZ/JLT, evaluate flag_z/flag_lt (FLAG_REG=1) or live zero/lt (FLAG_REG=0); taken gives a one-cycle jump_en pulse, not taken gives a one-cycle pc_en pulse.
REQ-022 SHALL, for J, pulse jump_en for one cycle; jump_en and pc_en SHALL never be high together.
REQ-023 SHALL, for IN, assert in_mux_en throughout EXEC/WAIT_IO; in the first cycle in_valid is high, pulse write_enable and pc_en and return to FETCH; otherwise stay in WAIT_IO.
REQ-024 SHALL, for OUT, pulse out_write_en and pc_en in the first cycle out_ready is high; otherwise stay in WAIT_IO with out_write_en low.
REQ-025 SHALL treat opcode >= 16 (OPW>4) as NOP: pc_en pulse, no write, illegal set until reset.
REQ-026 SHALL complete one instruction in 2 cycles minimum (FETCH + EXEC), plus WAIT_IO cycles for I/O.
REQ-027 SHALL hold outputs at NOP values (alu_control=001, all strobes 0) in FETCH and WAIT_IO, except in_mux_en per REQ-023.
REQ-028 SHALL make flag updates and jump evaluation in the same EXEC cycle impossible, since branches never update flags.

Reset
REQ-029 SHALL, while rst_n=0 at a clk edge, enter FETCH, clear the opcode latch to NOP, clear flag_z, flag_lt and illegal, and drive all strobes 0 with alu_control=001.
REQ-030 SHALL, on reset asserted mid-WAIT_IO, abandon the instruction with no write_enable, out_write_en or pc_en pulse.

Structure
REQ-031 SHALL place opcode localparams, ALU op encodings and the state enum in shared package brisc_pkg.
REQ-032 SHALL split into sub-module brisc_decode (combinational opcode to alu_control/im_sel/class), with the FSM and flags in brisc_ctrl_fsm.

Verification
REQ-033 SHALL test ADD: opcode=1, instr_valid=1 -> next cycle alu_control=000, write_enable=1, pc_en=1 for one cycle.
REQ-034 SHALL test flag latching: SUB with zero=1, then JZ with live zero=0, FLAG_REG=1 -> jump_en=1 one cycle, pc_en=0.
REQ-035 SHALL test IN stall: opcode=11 with in_valid=0 for 3 cycles, then 1 -> busy high 4 cycles, single write_enable and pc_en pulse on the in_valid cycle.
REQ-036 SHALL test OUT with reset: opcode=12, out_ready=0, rst_n=0 during WAIT_IO -> no out_write_en, state FETCH, instr_ready=1.
REQ-037 SHALL test illegal opcode: OPW=5, opcode=17 -> pc_en pulse, write_enable=0, illegal=1 held until reset.
REQ-038 SHALL test JLT not taken: flag_lt=0 -> pc_en=1, jump_en=0.
